// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the integer register file.
// Build option: REGFILE_BYPASS_EN enables write-back to read forwarding.
package regfile_sb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One-hot decode of a register index.
    function automatic logic [NREG-1:0] reg_onehot(
        input logic [REG_ADDR_W-1:0] addr
    );
        logic [NREG-1:0] v;
        v = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_sb_sb_bits.sv
// Busy scoreboard: one bit per register with issue/flush/write-back priority.
// Bit 0 (x0) is never set.
module sb_bits
    import regfile_sb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rd1_addr,
    input  logic [REG_ADDR_W-1:0] rd2_addr,
    output logic                  rd1_busy,
    output logic                  rd2_busy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Next-state: issue beats flush, flush beats write-back clear.
    always_comb begin
        set_vec  = set_en ? reg_onehot(set_addr) : '0;
        clr_vec  = clr_en ? reg_onehot(clr_addr) : '0;
        busy_nxt = busy;
        for (int i = 1; i < NREG; i++) begin
            if (set_vec[i]) begin
                busy_nxt[i] = 1'b1;
            end else if (flush) begin
                busy_nxt[i] = 1'b0;
            end else if (clr_vec[i]) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Per-port busy lookup.
    always_comb begin
        rd1_busy = busy[rd1_addr];
        rd2_busy = busy[rd2_addr];
    end

endmodule

// File: rtl/regfile_sb.sv
// 32 x XLEN register file with write scoreboard and decode hazard stall.
// Build option: REGFILE_BYPASS_EN forwards wb_data and clears busy on match.
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rs1_re,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic                  rs1_busy,
    input  logic                  rs2_re,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  rs2_busy,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  stall
);

    logic [XLEN-1:0] regs [NREG];
    logic            sb1_busy;
    logic            sb2_busy;
    logic            wb_ok;
    logic            issue_ok;

    assign wb_ok    = wb_we && (wb_addr != REG_ZERO);
    assign stall    = (rs1_re & rs1_busy) | (rs2_re & rs2_busy);
    assign issue_ok = issue_we && !stall && (issue_addr != REG_ZERO);

    // Data array write; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    sb_bits u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_ok),
        .set_addr (issue_addr),
        .clr_en   (wb_ok),
        .clr_addr (wb_addr),
        .flush    (flush),
        .rd1_addr (rs1_addr),
        .rd2_addr (rs2_addr),
        .rd1_busy (sb1_busy),
        .rd2_busy (sb2_busy)
    );

    // rs1 read port: zero when idle or x0, optional write-back forward.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_re && (rs1_addr != REG_ZERO)) begin
            rs1_data = regs[rs1_addr];
            rs1_busy = sb1_busy;
`ifdef REGFILE_BYPASS_EN
            if (wb_we && (wb_addr == rs1_addr)) begin
                rs1_data = wb_data;
                rs1_busy = 1'b0;
            end
`endif
        end
    end

    // rs2 read port: zero when idle or x0, optional write-back forward.
    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_re && (rs2_addr != REG_ZERO)) begin
            rs2_data = regs[rs2_addr];
            rs2_busy = sb2_busy;
`ifdef REGFILE_BYPASS_EN
            if (wb_we && (wb_addr == rs2_addr)) begin
                rs2_data = wb_data;
                rs2_busy = 1'b0;
            end
`endif
        end
    end

endmodule
